// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
//
// Shared ALU definitions for every block that talks to the ALU: the sixteen
// ALUFunc codes, the coarse operation-group encoding (taken from func[5:4]),
// a legality check for incoming function codes, and the state encoding used
// by the operation sequencer.
//
// No ports (package).
// ----------------------------------------------------------------------------
package alu_pkg;

    // ALUFunc codes understood by the ALU
    localparam logic [5:0] ALUFUNC_ADD = 6'b000000;
    localparam logic [5:0] ALUFUNC_SUB = 6'b000001;
    localparam logic [5:0] ALUFUNC_AND = 6'b011000;
    localparam logic [5:0] ALUFUNC_OR  = 6'b011110;
    localparam logic [5:0] ALUFUNC_XOR = 6'b010110;
    localparam logic [5:0] ALUFUNC_NOR = 6'b010001;
    localparam logic [5:0] ALUFUNC_A   = 6'b011010;
    localparam logic [5:0] ALUFUNC_SLL = 6'b100000;
    localparam logic [5:0] ALUFUNC_SRL = 6'b100001;
    localparam logic [5:0] ALUFUNC_SRA = 6'b100011;
    localparam logic [5:0] ALUFUNC_EQ  = 6'b110011;
    localparam logic [5:0] ALUFUNC_NEQ = 6'b110001;
    localparam logic [5:0] ALUFUNC_LT  = 6'b110101;
    localparam logic [5:0] ALUFUNC_LEZ = 6'b111101;
    localparam logic [5:0] ALUFUNC_GEZ = 6'b111001;
    localparam logic [5:0] ALUFUNC_GTZ = 6'b111111;

    // Operation groups: the top two bits of ALUFunc select the ALU sub-unit
    localparam logic [1:0] ALU_ARITH = 2'b00;
    localparam logic [1:0] ALU_LOGIC = 2'b01;
    localparam logic [1:0] ALU_SHIFT = 2'b10;
    localparam logic [1:0] ALU_CMP   = 2'b11;

    // Sequencer states
    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_EXEC = 2'd1,
        SEQ_RESP = 2'd2
    } seq_state_e;

    // 1 for exactly the sixteen defined ALUFunc codes
    function automatic logic alu_func_legal(input logic [5:0] func);
        logic legal;
        case (func)
            ALUFUNC_ADD, ALUFUNC_SUB,
            ALUFUNC_AND, ALUFUNC_OR, ALUFUNC_XOR, ALUFUNC_NOR, ALUFUNC_A,
            ALUFUNC_SLL, ALUFUNC_SRL, ALUFUNC_SRA,
            ALUFUNC_EQ, ALUFUNC_NEQ, ALUFUNC_LT,
            ALUFUNC_LEZ, ALUFUNC_GEZ, ALUFUNC_GTZ: legal = 1'b1;
            default:                               legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Sub-unit a function code belongs to (meaningful only for legal codes)
    function automatic logic [1:0] alu_func_group(input logic [5:0] func);
        logic [1:0] grp;
        case (func[5:4])
            2'b00:   grp = ALU_ARITH;
            2'b01:   grp = ALU_LOGIC;
            2'b10:   grp = ALU_SHIFT;
            default: grp = ALU_CMP;
        endcase
        return grp;
    endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// ----------------------------------------------------------------------------
// alu_op_sequencer
//
// Initiator end of the ALU debug/print interface. One ALU operation is taken
// per request handshake; its operands and function code are registered onto
// the ALU inputs and held stable. After LAT settle cycles the ALU result S is
// captured, a one-cycle print pulse is fired so the printer sees a consistent
// A/B/S snapshot, and the result is offered on a valid/ready response channel.
// Requests with an undefined ALUFunc skip execution and are answered straight
// away with rsp_illegal set and no print pulse.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req_valid/req_ready request handshake (ready only in IDLE, not in reset)
//   req_a, req_b        signed operands
//   req_signed          signed-compare select
//   req_func            ALUFunc code
//   alu_a, alu_b        operands to the ALU (held from accept to next accept)
//   alu_signed          Signed to the ALU
//   alu_func            ALUFunc to the ALU
//   alu_s               ALU result S
//   print_pulse         one-cycle printer strobe per legal op
//   rsp_valid/rsp_ready response handshake
//   rsp_s               captured result (0 for illegal requests)
//   rsp_illegal         request carried an undefined ALUFunc
//   op_count            completed legal ops, wraps modulo 2^CNT_W
// ----------------------------------------------------------------------------
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LAT    = 1,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic signed [DATA_W-1:0] req_a,
    input  logic signed [DATA_W-1:0] req_b,
    input  logic                     req_signed,
    input  logic [5:0]               req_func,
    output logic signed [DATA_W-1:0] alu_a,
    output logic signed [DATA_W-1:0] alu_b,
    output logic                     alu_signed,
    output logic [5:0]               alu_func,
    input  logic signed [DATA_W-1:0] alu_s,
    output logic                     print_pulse,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic signed [DATA_W-1:0] rsp_s,
    output logic                     rsp_illegal,
    output logic [CNT_W-1:0]         op_count
);

    // Settle counter only needs to hold LAT-1
    localparam int LAT_CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [LAT_CW-1:0] LAT_LOAD = LAT_CW'(LAT - 1);

    generate
        if (LAT < 1) begin : g_lat_check
            $error("alu_op_sequencer: LAT must be >= 1");
        end
        if (DATA_W != 32) begin : g_width_check
            $error("alu_op_sequencer: the ALU interface is fixed at 32 bits");
        end
    endgenerate

    seq_state_e                state_q,       state_d;
    logic [LAT_CW-1:0]         cnt_q,         cnt_d;
    logic signed [DATA_W-1:0]  alu_a_q,       alu_a_d;
    logic signed [DATA_W-1:0]  alu_b_q,       alu_b_d;
    logic                      alu_signed_q,  alu_signed_d;
    logic [5:0]                alu_func_q,    alu_func_d;
    logic                      print_pulse_q, print_pulse_d;
    logic                      rsp_valid_q,   rsp_valid_d;
    logic signed [DATA_W-1:0]  rsp_s_q,       rsp_s_d;
    logic                      rsp_illegal_q, rsp_illegal_d;
    logic [CNT_W-1:0]          op_count_q,    op_count_d;

    // Combinational so that ready drops in the same cycle reset is raised
    assign req_ready = (state_q == SEQ_IDLE) && !reset;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_signed_d  = alu_signed_q;
        alu_func_d    = alu_func_q;
        print_pulse_d = 1'b0;           // pulse lasts only the first RESP cycle
        rsp_valid_d   = rsp_valid_q;
        rsp_s_d       = rsp_s_q;
        rsp_illegal_d = rsp_illegal_q;
        op_count_d    = op_count_q;

        case (state_q)
            SEQ_IDLE: begin
                if (req_valid && req_ready) begin
                    // Operands go to the ALU even for an illegal code; they
                    // stay put until the next accepted request.
                    alu_a_d      = req_a;
                    alu_b_d      = req_b;
                    alu_signed_d = req_signed;
                    alu_func_d   = req_func;
                    if (alu_func_legal(req_func)) begin
                        cnt_d   = LAT_LOAD;
                        state_d = SEQ_EXEC;
                    end else begin
                        rsp_s_d       = '0;
                        rsp_illegal_d = 1'b1;
                        rsp_valid_d   = 1'b1;
                        state_d       = SEQ_RESP;
                    end
                end
            end

            SEQ_EXEC: begin
                if (cnt_q == '0) begin
                    // ALU has settled: snapshot S and notify the printer.
                    // The op is counted here, not at the response handshake.
                    rsp_s_d       = alu_s;
                    rsp_illegal_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    print_pulse_d = 1'b1;
                    op_count_d    = op_count_q + CNT_W'(1);
                    state_d       = SEQ_RESP;
                end else begin
                    cnt_d = cnt_q - LAT_CW'(1);
                end
            end

            SEQ_RESP: begin
                // Returning to IDLE here means the next accept is at least one
                // edge after the response completes.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = SEQ_IDLE;
                end
            end

            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= SEQ_IDLE;
            cnt_q         <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_signed_q  <= 1'b0;
            alu_func_q    <= '0;
            print_pulse_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_s_q       <= '0;
            rsp_illegal_q <= 1'b0;
            op_count_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_signed_q  <= alu_signed_d;
            alu_func_q    <= alu_func_d;
            print_pulse_q <= print_pulse_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_s_q       <= rsp_s_d;
            rsp_illegal_q <= rsp_illegal_d;
            op_count_q    <= op_count_d;
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_signed  = alu_signed_q;
    assign alu_func    = alu_func_q;
    assign print_pulse = print_pulse_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_s       = rsp_s_q;
    assign rsp_illegal = rsp_illegal_q;
    assign op_count    = op_count_q;

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Initiator end of the ALU debug/print interface. Accepts one ALU operation per request handshake and drives A, B, Signed and ALUFunc onto the ALU, holding them stable. Waits a fixed ALU settle latency, captures S, and fires a one-cycle print pulse so the ALU printer logs a consistent snapshot. Returns the result on a valid/ready response channel. Used by the CPU test harness and the ALU bring-up bench.

Parameters:
DATA_W, 32, operand/result width (the ALU interface is fixed at 32; other values are unsupported).
LAT, 1, ALU settle cycles between driving operands and capturing S; must be >=1; 0 is an elaboration error.
CNT_W, 16, width of op_count.

Ports:
clk  in  1  single clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  high only in IDLE and not in reset.
req_a  in  32  operand A (signed).
req_b  in  32  operand B (signed).
req_signed  in  1  signed-compare select.
req_func  in  6  ALUFunc code.
alu_a  out  32  to ALU A.
alu_b  out  32  to ALU B.
alu_signed  out  1  to ALU Signed.
alu_func  out  6  to ALU ALUFunc.
alu_s  in  32  ALU result S.
print_pulse  out  1  to printer pulse; one-cycle high per legal op.
rsp_valid  out  1  response present.
rsp_ready  in  1  response consumed.
rsp_s  out  32  captured result.
rsp_illegal  out  1  request had an undefined ALUFunc.
op_count  out  CNT_W  completed legal ops, wraps.

Behaviour:
- Reset: state=IDLE; alu_a/alu_b=0, alu_signed=0, alu_func=0, print_pulse=0, rsp_valid=0, rsp_s=0, rsp_illegal=0, op_count=0. req_ready=0 while reset is high. Reset at any state aborts the op: no pulse, no response, op_count unchanged.
- States: IDLE, EXEC, RESP.
- IDLE: req_ready=1. On req_valid&req_ready at edge E0, latch req_* into alu_*.
  - Legal func: go to EXEC with cnt=LAT-1.
  - Illegal func: go to RESP with rsp_s=0, rsp_illegal=1, rsp_valid=1, no print_pulse.
- Legal codes (16): ADD 000000, SUB 000001, AND 011000, OR 011110, XOR 010110, NOR 010001, A 011010, SLL 100000, SRL 100001, SRA 100011, EQ 110011, NEQ 110001, LT 110101, LEZ 111101, GEZ 111001, GTZ 111111.
- EXEC: cnt decrements each edge. At the edge where cnt==0 (edge E0+LAT): rsp_s<=alu_s, rsp_illegal<=0, rsp_valid<=1, print_pulse<=1, op_count<=op_count+1 (modulo 2^CNT_W), state=RESP.
- RESP: print_pulse high for exactly its first cycle, then 0 regardless of rsp_ready. rsp_valid and rsp_s hold until rsp_valid&rsp_ready at an edge, then IDLE with rsp_valid=0.
- alu_* outputs are held stable from E0 through the end of RESP and keep the last op's values in IDLE. The printer therefore samples a stable A/B/S at the rising edge of print_pulse.
- No overlap: a new request is never accepted in the cycle a response completes. Minimum period per legal op is LAT+2 cycles with rsp_ready tied high.
- Latency: with LAT=1, accept at E0, rsp_valid and print_pulse high after E1.
- op_count counts legal ops at capture, not at response handshake; 0xFFFF+1 -> 0x0000.

Decomposition:
- Shared package alu_pkg: the 16 ALUFUNC_* localparams, the ALU_ARITH/LOGIC/SHIFT/CMP group codes, and the function alu_func_legal(func) returning 1 for the 16 codes.
- The printer and any future ALU block import this package instead of redeclaring the codes.
- No sub-module. FSM, latency counter and op counter live in one module. Compile-time LAT>=1 check.

Test Plan:
- LAT=1, behavioural ALU model, ADD A=5 B=7 -> alu_* driven after E0; rsp_valid=1, print_pulse=1, rsp_s=12 after E1; pulse low after E2; op_count=1.
- Illegal func 6'b000010 -> rsp_valid after E0 with rsp_illegal=1, rsp_s=0; print_pulse never high; op_count unchanged.
- SUB A=3 B=10, rsp_ready low 5 cycles -> rsp_s=32'hFFFFFFF9 held; alu_a=3, alu_b=10 stable all 5 cycles; req_ready=0 throughout; print_pulse high exactly 1 cycle.
- LAT=3, LT signed A=-1 B=1 -> rsp_s=1 appears exactly 3 edges after accept; req_valid asserted during EXEC/RESP not accepted.
- Reset asserted one cycle into EXEC (LAT=3) -> next cycle IDLE, all outputs 0, no pulse, no response, op_count=0.
- Preload-free wrap: CNT_W=2, run 5 legal ops back-to-back with rsp_ready=1 -> op_count sequence 1,2,3,0,1; each op period is LAT+2 cycles.
